frame_writer: RTL and testbench

Writer side of the image RAM that the VGA pixel fetcher reads. Accepts a raster-ordered stream of 8-bit grey pixels over a valid/ready handshake and writes one pixel per 32-bit RAM word at IMAGE_START_ADDR + row*IMG_WIDTH + col. The RAM write port has Avalon-style wait-request back-pressure. Frames are started by a start pulse from the processing core, and completion is reported with a done pulse.

---
 rtl/frame_writer.sv | 134 +++++++++++++
 tb/tb_frame_writer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_writer.sv
// Raster-order pixel stream to image RAM writer. Each grey pixel goes into one 32-bit
// word at IMAGE_START_ADDR + row*IMG_WIDTH + col. The RAM port applies wait-request back-pressure.
module frame_writer #(
    parameter int IMG_WIDTH        = 300,
    parameter int IMG_HEIGHT       = 300,
    parameter int IMAGE_START_ADDR = 100,
    parameter int ADDR_W           = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    output logic              pix_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_wait,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] START_PTR = ADDR_W'(IMAGE_START_ADDR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              abort_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;

    logic              accept;
    logic              wr_complete;
    logic              out_free;
    logic [COL_W-1:0]  col_d;
    logic [ROW_W-1:0]  row_d;
    logic [ADDR_W-1:0] ptr_d;
    logic              last_pix;

    // The output register can take a new pixel if it is empty or draining this cycle.
    assign wr_complete = wr_en_q && !wr_wait;
    assign out_free    = !wr_en_q || !wr_wait;
    assign pix_ready   = (state_q == RUN) && out_free && !abort;
    assign accept      = pix_valid && pix_ready;

    // Running pointer tracks row*IMG_WIDTH+col without a multiplier.
    assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign ptr_d    = ptr_q + ADDR_W'(1);
    assign col_d    = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
    assign row_d    = (col_q == COL_LAST && row_q != ROW_LAST) ? row_q + ROW_W'(1) : row_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            ptr_q     <= '0;
            abort_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            if (wr_complete && !accept) begin
                wr_en_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        col_q   <= '0;
                        row_q   <= '0;
                        ptr_q   <= START_PTR;
                        abort_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= ptr_q;
                        wr_data_q <= {24'b0, pix_data};
                        ptr_q     <= ptr_d;
                        col_q     <= col_d;
                        row_q     <= row_d;
                        if (last_pix) begin
                            state_q <= DRAIN;
                        end
                    end else if (abort) begin
                        // A stalled write must still finish before returning to IDLE.
                        if (out_free) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DRAIN;
                            abort_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_free) begin
                        state_q <= (abort_q || abort) ? IDLE : DONE;
                    end else if (abort) begin
                        abort_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q == RUN) || (state_q == DRAIN);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer on a 4x3 frame at base address 100: streaming, stalls,
// valid gaps, abort, stray starts and asynchronous reset.
module tb_frame_writer;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int START = 100;
    localparam int NPIX  = W * H;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic        wr_en;
    logic [21:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_wait;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    frame_writer #(
        .IMG_WIDTH(W),
        .IMG_HEIGHT(H),
        .IMAGE_START_ADDR(START),
        .ADDR_W(22)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .pix_valid(pix_valid),
        .pix_data(pix_data),
        .pix_ready(pix_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_wait(wr_wait),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
        chk({tag, "_wr_en"},     32'(wr_en),     32'd0);
        chk({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
        chk({tag, "_wr_data"},   wr_data,        32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
    endtask

    // Runs one frame. The expected handshake behaviour is tracked cycle by cycle, and
    // the completed-write sequence is compared with the raster addresses 100, 101, ...
    task automatic run_frame(input int stall_addr, input int stall_n, input int gap_pct,
                             input int abort_addr, input bit start_mid, input bit start_done,
                             input int reset_at_k,
                             output int nwr, output int done_cnt, output int done_cyc,
                             output int last_wr_cyc, output int first_wen_cyc,
                             output int hold_cnt);
        int m_state = 0;  // 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
        int m_k = 0;
        bit m_wen = 0;
        int m_addr = 0;
        int m_data = 0;
        bit m_ab = 0;
        int stall_left = stall_n;
        int stall_seen = 0;
        bit aborted = 0;
        int idle_cnt = 0;
        bit exp_ready, acc, cmp;
        nwr = 0; done_cnt = 0; done_cyc = -1; last_wr_cyc = -1; first_wen_cyc = -1; hold_cnt = 0;
        for (int cyc = 0; cyc < 300 && idle_cnt < 3; cyc++) begin
            @(posedge clk);
            #1;
            start = (cyc == 0) || (start_mid && m_state == 1 && m_k == 5)
                    || (start_done && m_state == 3);
            wr_wait = 1'b0;
            if (m_wen && m_addr == stall_addr && stall_left > 0) begin
                wr_wait = 1'b1;
                stall_left--;
                stall_seen++;
            end
            abort = 1'b0;
            if (abort_addr >= 0 && !aborted && wr_wait && m_addr == abort_addr && stall_seen == 2) begin
                abort = 1'b1;
                aborted = 1'b1;
            end
            pix_valid = (m_k < NPIX) && ($urandom_range(99) >= 32'(gap_pct));
            pix_data  = 8'(16 + m_k);
            #1;
            exp_ready = (m_state == 1) && (!m_wen || !wr_wait) && !abort;
            chk("pix_ready", 32'(pix_ready), 32'(exp_ready));
            chk("wr_en", 32'(wr_en), 32'(m_wen));
            if (m_wen) begin
                chk("wr_addr", 32'(wr_addr), 32'(m_addr));
                chk("wr_data", wr_data, 32'(m_data));
            end
            chk("busy", 32'(busy), 32'(m_state == 1 || m_state == 2));
            chk("done", 32'(done), 32'(m_state == 3));
            if (wr_en && !wr_wait) begin
                chk("wr_seq", 32'(wr_addr), 32'(START + nwr));
                nwr++;
                last_wr_cyc = cyc;
            end
            if (wr_en && 32'(wr_addr) == 32'(stall_addr)) hold_cnt++;
            if (wr_en && first_wen_cyc < 0) first_wen_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (reset_at_k >= 0 && m_state == 1 && m_k == reset_at_k) begin
                rst_n = 1'b0;
                #1;
                chk_all_zero("async_rst");
                return;
            end
            acc = pix_valid && exp_ready;
            cmp = m_wen && !wr_wait;
            case (m_state)
                0: if (start) begin m_state = 1; m_k = 0; m_ab = 0; end
                1: begin
                    if (acc) begin
                        m_wen = 1; m_addr = START + m_k; m_data = 16 + m_k; m_k++;
                        if (m_k == NPIX) m_state = 2;
                    end else begin
                        if (cmp) m_wen = 0;
                        if (abort) begin
                            if (!m_wen) m_state = 0;
                            else begin m_state = 2; m_ab = 1; end
                        end
                    end
                end
                2: begin
                    if (cmp) m_wen = 0;
                    if (!m_wen) m_state = (m_ab || abort) ? 0 : 3;
                    else if (abort) m_ab = 1;
                end
                default: m_state = 0;
            endcase
            if (m_state == 0 && cyc > 0) idle_cnt++;
        end
        start = 1'b0; abort = 1'b0; pix_valid = 1'b0; wr_wait = 1'b0;
        if (reset_at_k < 0) chk("frame_ends_in_budget", 32'(idle_cnt >= 3), 32'd1);
    endtask

    int nwr, dcnt, dcyc, lwc, fwc, hold;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pix_valid = 1'b0; pix_data = 8'd0; wr_wait = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: continuous stream, no back-pressure
        run_frame(-1, 0, 0, -1, 0, 0, -1, nwr, dcnt, dcyc, lwc, fwc, hold);
        $display("T1 stream: writes=%0d done=%0d done_cyc=%0d first_wen=%0d", nwr, dcnt, dcyc, fwc);
        chk("t1_writes", 32'(nwr), 32'd12);
        chk("t1_done_cnt", 32'(dcnt), 32'd1);
        chk("t1_first_wen_cyc", 32'(fwc), 32'd2);
        chk("t1_last_wr_cyc", 32'(lwc), 32'd13);
        chk("t1_done_cyc", 32'(dcyc), 32'd14);
        chk("t1_busy_after", 32'(busy), 32'd0);

        // 2: stall the write to 105 for three cycles
        run_frame(105, 3, 0, -1, 0, 0, -1, nwr, dcnt, dcyc, lwc, fwc, hold);
        $display("T2 stall: writes=%0d hold105=%0d done_cyc=%0d", nwr, hold, dcyc);
        chk("t2_writes", 32'(nwr), 32'd12);
        chk("t2_hold_105", 32'(hold), 32'd4);
        chk("t2_done_cnt", 32'(dcnt), 32'd1);
        chk("t2_done_cyc", 32'(dcyc), 32'd17);

        // 3: random valid gaps
        run_frame(-1, 0, 50, -1, 0, 0, -1, nwr, dcnt, dcyc, lwc, fwc, hold);
        $display("T3 gaps: writes=%0d done=%0d", nwr, dcnt);
        chk("t3_writes", 32'(nwr), 32'd12);
        chk("t3_done_cnt", 32'(dcnt), 32'd1);
        chk("t3_done_after_last_wr", 32'(dcyc), 32'(lwc + 1));

        // 4: abort during a stalled write to 106
        run_frame(106, 3, 0, 106, 0, 0, -1, nwr, dcnt, dcyc, lwc, fwc, hold);
        $display("T4 abort: writes=%0d hold106=%0d done=%0d", nwr, hold, dcnt);
        chk("t4_writes", 32'(nwr), 32'd7);
        chk("t4_hold_106", 32'(hold), 32'd4);
        chk("t4_no_done", 32'(dcnt), 32'd0);
        chk("t4_busy_after", 32'(busy), 32'd0);
        run_frame(-1, 0, 0, -1, 0, 0, -1, nwr, dcnt, dcyc, lwc, fwc, hold);
        $display("T4 restart: writes=%0d done=%0d", nwr, dcnt);
        chk("t4_restart_writes", 32'(nwr), 32'd12);

        // 5: stray start pulses mid-frame and in the DONE cycle
        run_frame(-1, 0, 0, -1, 1, 1, -1, nwr, dcnt, dcyc, lwc, fwc, hold);
        $display("T5 stray start: writes=%0d done=%0d", nwr, dcnt);
        chk("t5_writes", 32'(nwr), 32'd12);
        chk("t5_done_cnt", 32'(dcnt), 32'd1);
        chk("t5_busy_after", 32'(busy), 32'd0);

        // 6: asynchronous reset mid-frame, then a clean frame
        run_frame(-1, 0, 0, -1, 0, 0, 6, nwr, dcnt, dcyc, lwc, fwc, hold);
        $display("T6 reset mid-frame after %0d writes", nwr);
        start = 1'b0; abort = 1'b0; pix_valid = 1'b0; wr_wait = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_held");
        rst_n = 1'b1;
        run_frame(-1, 0, 0, -1, 0, 0, -1, nwr, dcnt, dcyc, lwc, fwc, hold);
        $display("T6 after reset: writes=%0d done=%0d", nwr, dcnt);
        chk("t6_writes", 32'(nwr), 32'd12);
        chk("t6_done_cnt", 32'(dcnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
